// File: rtl/clb_pkg.sv
// Shared definitions for the CLB-128 CBC sequencing stage: widths, mode codes, FSM states.
package clb_pkg;

  localparam int CLB_BLOCK_W = 128;
  localparam int CLB_KEY_W   = 128;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_KICK = 2'd1,
    ST_RUN  = 2'd2,
    ST_HOLD = 2'd3
  } clb_state_e;

endpackage

// File: rtl/clb_chain_xor.sv
// CBC chain register with iv load and the mode-dependent pre-core / post-core XOR paths.
module clb_chain_xor
  import clb_pkg::*;
#(
  parameter int W = CLB_BLOCK_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] iv,
  input  logic         update,
  input  logic         pre_mode,
  input  logic [W-1:0] in_data,
  input  logic         post_mode,
  input  logic [W-1:0] core_out,
  input  logic [W-1:0] saved_in,
  output logic [W-1:0] textin,
  output logic [W-1:0] result
);

  logic [W-1:0] chain;

  // Encrypt chains on the ciphertext just produced, decrypt on the ciphertext just consumed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        chain <= '0;
    else if (load)   chain <= iv;
    else if (update) chain <= (post_mode == MODE_ENC) ? core_out : saved_in;
  end

  always_comb begin
    textin = (pre_mode  == MODE_ENC) ? (in_data ^ chain) : in_data;
    result = (post_mode == MODE_ENC) ? core_out : (core_out ^ chain);
  end

endmodule

// File: rtl/clb_cbc_ctrl.sv
// CBC sequencing controller in front of one clb_ecb core: restarts the core per block.
// Optional core-timeout detection is enabled by defining CLB_TIMEOUT_EN.
module clb_cbc_ctrl
  import clb_pkg::*;
#(
  parameter int BLOCK_W = CLB_BLOCK_W,
  parameter int KEY_W   = CLB_KEY_W,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_mode,
  input  logic [KEY_W-1:0]   key,
  input  logic [BLOCK_W-1:0] iv,
  input  logic               iv_load,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic               core_rst,
  output logic               core_mode,
  output logic [BLOCK_W-1:0] core_textin,
  output logic [KEY_W-1:0]   core_key,
  input  logic [BLOCK_W-1:0] core_textout,
  input  logic               core_enable,
  output logic               busy,
  output logic               err_timeout
);

  if (TIMEOUT < 1) begin : g_cfg_chk
    $error("TIMEOUT must be at least 1");
  end

  clb_state_e         state, state_n;
  logic               rdy_q;
  logic [BLOCK_W-1:0] saved_in, textin_d, result_d;
  logic               accept, load, done, xfer, tmo;

  // iv_load gates ready combinationally so a block offered alongside it waits exactly one cycle.
  assign in_ready = rdy_q & ~iv_load;

`ifdef CLB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  logic          err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      cnt   <= (state == ST_RUN) ? cnt + CW'(1) : '0;
      err_q <= err_q | tmo;
    end
  end

  assign tmo         = (state == ST_RUN) && !core_enable && (cnt == CW'(TIMEOUT - 1));
  assign err_timeout = err_q;
`else
  assign tmo         = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: if (accept) state_n = ST_KICK;
      ST_KICK: state_n = ST_RUN;
      ST_RUN: begin
        if (core_enable) state_n = ST_HOLD;
        else if (tmo)    state_n = ST_IDLE;
      end
      ST_HOLD: if (xfer) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    accept = 1'b0;
    load   = 1'b0;
    done   = 1'b0;
    xfer   = 1'b0;
    case (state)
      ST_IDLE: begin
        load   = iv_load;
        accept = in_valid & in_ready;
      end
      ST_RUN:  done = core_enable;
      ST_HOLD: xfer = out_valid & out_ready;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_q       <= 1'b0;
      busy        <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      core_rst    <= 1'b0;
      core_mode   <= 1'b0;
      core_textin <= '0;
      core_key    <= '0;
      saved_in    <= '0;
    end else begin
      rdy_q <= (state_n == ST_IDLE);
      busy  <= (state_n != ST_IDLE);
      if (accept) begin
        core_mode   <= cfg_mode;
        core_key    <= key;
        core_textin <= textin_d;
        saved_in    <= in_data;
        core_rst    <= 1'b0;
      end
      if (state == ST_KICK) core_rst <= 1'b1;
      if (done) begin
        out_data  <= result_d;
        out_valid <= 1'b1;
      end
      if (xfer) out_valid <= 1'b0;
    end
  end

  clb_chain_xor #(.W(BLOCK_W)) u_chain (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .iv        (iv),
    .update    (done),
    .pre_mode  (cfg_mode),
    .in_data   (in_data),
    .post_mode (core_mode),
    .core_out  (core_textout),
    .saved_in  (saved_in),
    .textin    (textin_d),
    .result    (result_d)
  );

endmodule

// File: tb/tb_clb_cbc_ctrl.sv
// Bench for clb_cbc_ctrl with a behavioural stand-in for clb_ecb (invertible rotate/XOR cipher).
module tb_clb_cbc_ctrl;
  localparam int W   = 128;
  localparam int LAT = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cfg_mode = 1'b0;
  logic [W-1:0] key = '0;
  logic [W-1:0] iv = '0;
  logic         iv_load = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_data;
  logic         core_rst, core_mode;
  logic [W-1:0] core_textin, core_key;
  logic [W-1:0] core_textout = '0;
  logic         core_enable = 1'b0;
  logic         busy, err_timeout;

  int errs = 0;
  int checks = 0;

  clb_cbc_ctrl #(.BLOCK_W(W), .KEY_W(W), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .key(key), .iv(iv), .iv_load(iv_load),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .core_rst(core_rst), .core_mode(core_mode), .core_textin(core_textin), .core_key(core_key),
    .core_textout(core_textout), .core_enable(core_enable), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] enc_f(input logic [W-1:0] x, input logic [W-1:0] k);
    return {x[W-6:0], x[W-1:W-5]} ^ k;
  endfunction

  function automatic logic [W-1:0] dec_f(input logic [W-1:0] y, input logic [W-1:0] k);
    logic [W-1:0] t;
    t = y ^ k;
    return {t[4:0], t[W-1:5]};
  endfunction

  // Core stand-in: restarted by core_rst low, result valid LAT cycles later, held until restart.
  logic stall = 1'b0;
  int   cnt_m = 0;
  always @(posedge clk or negedge core_rst) begin
    if (!core_rst) begin
      core_enable <= 1'b0;
      cnt_m       <= 0;
    end else if (!core_enable && !stall) begin
      if (cnt_m == LAT - 1) begin
        core_enable  <= 1'b1;
        core_textout <= core_mode ? dec_f(core_textin, core_key) : enc_f(core_textin, core_key);
      end else begin
        cnt_m <= cnt_m + 1;
      end
    end
  end

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic load_iv(input logic [W-1:0] v);
    iv = v;
    iv_load = 1'b1;
    @(negedge clk);
    iv_load = 1'b0;
  endtask

  task automatic send(input logic m, input logic [W-1:0] k, input logic [W-1:0] d);
    int n = 0;
    cfg_mode = m;
    key      = k;
    in_data  = d;
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errs++;
      $display("FAIL accept_wait: got in_ready=0 want 1 within 20 cycles");
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("accept_ready_drop", in_ready, 0);
    check("core_cfg", {core_mode, core_key}, {m, k});
  endtask

  logic [W-1:0] last_out;

  task automatic recv(input logic [W-1:0] e, input string nm);
    int n = 0;
    int en = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
      if (core_enable && !out_valid) en++;
    end
    if (!out_valid) begin
      checks++;
      errs++;
      $display("FAIL %s_wait: got out_valid=0 want 1 within 50 cycles", nm);
    end
    check(nm, out_data, e);
    check({nm, "_lat"}, en, 1);
    last_out = out_data;
    if (out_ready) begin
      @(negedge clk);
      check({nm, "_post"}, {out_valid, in_ready}, 2'b01);
    end
  endtask

  typedef struct {
    logic         ld;
    logic [W-1:0] ivv;
    logic         md;
    logic [W-1:0] k;
    logic [W-1:0] d;
    logic [W-1:0] e;
  } vec_t;

  vec_t tv [9];

  localparam logic [W-1:0] K1  = 128'hf8824664994aef9b418ca843498d658f;
  localparam logic [W-1:0] P0  = 128'hfe5180a5414b65bf26f6d2122b004aff;
  localparam logic [W-1:0] IV2 = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [W-1:0] K2  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [W-1:0] A0  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [W-1:0] A1  = 128'h1032547698badcfe0123456789abcdef;
  localparam logic [W-1:0] A2  = 128'hdeadbeefcafebabe0badf00d12345678;
  localparam logic [W-1:0] P3  = 128'h5a5a5a5aa5a5a5a55a5a5a5aa5a5a5a5;
  localparam logic [W-1:0] P4  = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [W-1:0] P5  = 128'h8899aabbccddeeff0011223344556677;
  localparam logic [W-1:0] P6  = 128'h13579bdf02468ace13579bdf02468ace;
  localparam logic [W-1:0] P7  = 128'hfedcba98765432100123456789abcdef;
  localparam logic [W-1:0] IVX = 128'hc0ffee00c0ffee00c0ffee00c0ffee00;
  localparam logic [W-1:0] IVY = 128'h11111111222222223333333344444444;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] c0, c1, c2, z0, z1, c1_dut, mc, e;
    logic         hold_ok;
    c0 = enc_f(A0 ^ IV2, K2);
    c1 = enc_f(A1 ^ c0, K2);
    c2 = enc_f(A2 ^ c1, K2);
    z0 = enc_f(A0, K2);
    z1 = enc_f(A1 ^ z0, K2);
    tv[0] = '{1'b1, '0,  1'b0, K1, P0, enc_f(P0, K1)};
    tv[1] = '{1'b1, IV2, 1'b0, K2, A0, c0};
    tv[2] = '{1'b0, '0,  1'b0, K2, A1, c1};
    tv[3] = '{1'b0, '0,  1'b0, K2, A2, c2};
    tv[4] = '{1'b1, IV2, 1'b1, K2, c0, A0};
    tv[5] = '{1'b0, '0,  1'b1, K2, c1, A1};
    tv[6] = '{1'b0, '0,  1'b1, K2, c2, A2};
    tv[7] = '{1'b1, '0,  1'b0, K2, A0, z0};
    tv[8] = '{1'b0, '0,  1'b0, K2, A1, z1};
    c1_dut = '0;

    repeat (2) @(negedge clk);
    check("reset_ctrl", {in_ready, out_valid, busy, err_timeout, core_rst, core_mode}, 6'b0);
    check("reset_data", {out_data, core_textin}, '0);
    check("reset_key", core_key, '0);
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_reset", in_ready, 1);

    for (int i = 0; i < 9; i++) begin
      if (tv[i].ld) load_iv(tv[i].ivv);
      send(tv[i].md, tv[i].k, tv[i].d);
      recv(tv[i].e, $sformatf("vec%0d", i));
      if (i == 2) c1_dut = last_out;
    end
    checks++;
    if (last_out === c1_dut) begin
      errs++;
      $display("FAIL iv_dependence: got %h want value different from %h", last_out, c1_dut);
    end
    mc = z1;

    // Backpressure: result held for 20 cycles, no core restart meanwhile.
    out_ready = 1'b0;
    e = enc_f(P3 ^ mc, K2);
    send(1'b0, K2, P3);
    recv(e, "bp_data");
    hold_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_data !== e || !out_valid || in_ready || !core_rst || !busy) hold_ok = 1'b0;
    end
    check("bp_hold", hold_ok, 1);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release", {out_valid, in_ready}, 2'b01);
    mc = e;

    // iv_load and a block in the same IDLE cycle: block waits one cycle and uses the new iv.
    iv = IVX;
    iv_load = 1'b1;
    cfg_mode = 1'b0;
    key = K2;
    in_data = P4;
    in_valid = 1'b1;
    #1;
    check("ivld_blocks_ready", in_ready, 0);
    @(negedge clk);
    iv_load = 1'b0;
    #1;
    check("ivld_ready_next", in_ready, 1);
    send(1'b0, K2, P4);
    e = enc_f(P4 ^ IVX, K2);
    recv(e, "ivld_data");
    mc = e;

    // iv_load during RUN is ignored.
    send(1'b0, K2, P5);
    iv = IVY;
    iv_load = 1'b1;
    repeat (2) @(negedge clk);
    iv_load = 1'b0;
    e = enc_f(P5 ^ mc, K2);
    recv(e, "run_ivld_ignored");

    // Async reset while the core is stalled in RUN.
    stall = 1'b1;
    send(1'b0, K1, P0);
    repeat (3) @(negedge clk);
    check("mid_busy", {busy, core_rst}, 2'b11);
    #2 rst = 1'b0;
    #1;
    check("mid_reset_ctrl", {in_ready, out_valid, busy, err_timeout, core_rst, core_mode}, 6'b0);
    check("mid_reset_data", {out_data, core_textin}, '0);
    @(negedge clk);
    rst = 1'b1;
    stall = 1'b0;
    @(negedge clk);
    send(1'b0, K1, P0);
    recv(enc_f(P0, K1), "post_reset_ecb");
    mc = enc_f(P0, K1);

`ifdef CLB_TIMEOUT_EN
    begin
      int n, runc, ovs;
      n = 0;
      runc = 0;
      ovs = 0;
      stall = 1'b1;
      send(1'b0, K2, P6);
      while (!err_timeout && n < 40) begin
        @(negedge clk);
        n++;
        if (busy && !err_timeout) runc++;
        if (out_valid) ovs++;
      end
      check("tmo_run_cycles", runc, 8);
      check("tmo_state", {err_timeout, busy, in_ready, ovs != 0}, 4'b1010);
      stall = 1'b0;
      send(1'b0, K2, P7);
      recv(enc_f(P7 ^ mc, K2), "tmo_chain_kept");
      check("tmo_sticky", err_timeout, 1);
      rst = 1'b0;
      #1;
      check("tmo_cleared", err_timeout, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
